// File: rtl/control_unit.sv
// Multicycle Moore control FSM for the single-memory CPU datapath.
// Outputs decode from the state register; the only qualified strobes are BRANCH pc_w (zr) and WB_ALU rb_w (ovf_q).
module control_unit (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zr,
    input  logic       of,
    output logic       pc_w,
    output logic       mem_w,
    output logic       ir_w,
    output logic       rb_w,
    output logic       ab_w,
    output logic       alu_w,
    output logic       mdr_w,
    output logic [1:0] sel_mem,
    output logic       sel_a,
    output logic [1:0] sel_b,
    output logic [2:0] ula_c,
    output logic       sel_wreg,
    output logic       sel_wdata,
    output logic [1:0] sel_pc,
    output logic       rst_out,
    output logic       ovf_trap,
    output logic       illegal_op,
    output logic [3:0] state_o
);

    typedef enum logic [3:0] {
        S_RESET    = 4'd0,
        S_FETCH0   = 4'd1,
        S_FETCH1   = 4'd2,
        S_DECODE   = 4'd3,
        S_EXEC_R   = 4'd4,
        S_EXEC_I   = 4'd5,
        S_WB_ALU   = 4'd6,
        S_MEM_ADDR = 4'd7,
        S_MEM_RD0  = 4'd8,
        S_MEM_RD1  = 4'd9,
        S_WB_LW    = 4'd10,
        S_MEM_WR   = 4'd11,
        S_BRANCH   = 4'd12,
        S_JUMP     = 4'd13,
        S_ILLEGAL  = 4'd14,
        S_UNUSED   = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;

    state_t     state_q, state_d;
    logic [5:0] op_q, op_d;
    logic [5:0] fn_q, fn_d;
    logic       ovf_q, ovf_d;

    function automatic logic [2:0] r_alu_op(input logic [5:0] fn);
        case (fn)
            FN_ADD:  r_alu_op = 3'b001;
            FN_SUB:  r_alu_op = 3'b010;
            FN_AND:  r_alu_op = 3'b011;
            default: r_alu_op = 3'b000;
        endcase
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_RESET;
            op_q    <= 6'h00;
            fn_q    <= 6'h00;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            fn_q    <= fn_d;
            ovf_q   <= ovf_d;
        end
    end

    // Opcode/funct are captured leaving DECODE so later states ignore IR changes.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        fn_d    = fn_q;
        ovf_d   = ovf_q;
        case (state_q)
            S_RESET:  state_d = S_FETCH0;
            S_FETCH0: state_d = S_FETCH1;
            S_FETCH1: state_d = S_DECODE;
            S_DECODE: begin
                op_d = opcode;
                fn_d = funct;
                case (opcode)
                    OP_RTYPE: state_d = (r_alu_op(funct) != 3'b000) ? S_EXEC_R : S_ILLEGAL;
                    OP_ADDI:  state_d = S_EXEC_I;
                    OP_LW,
                    OP_SW:    state_d = S_MEM_ADDR;
                    OP_BEQ:   state_d = S_BRANCH;
                    OP_J:     state_d = S_JUMP;
                    default:  state_d = S_ILLEGAL;
                endcase
            end
            S_EXEC_R: begin
                ovf_d   = (fn_q == FN_AND) ? 1'b0 : of;
                state_d = S_WB_ALU;
            end
            S_EXEC_I: begin
                ovf_d   = of;
                state_d = S_WB_ALU;
            end
            S_MEM_ADDR: state_d = (op_q == OP_LW) ? S_MEM_RD0 : S_MEM_WR;
            S_MEM_RD0:  state_d = S_MEM_RD1;
            S_MEM_RD1:  state_d = S_WB_LW;
            default:    state_d = S_FETCH0;
        endcase
    end

    always_comb begin
        pc_w       = 1'b0;
        mem_w      = 1'b0;
        ir_w       = 1'b0;
        rb_w       = 1'b0;
        ab_w       = 1'b0;
        alu_w      = 1'b0;
        mdr_w      = 1'b0;
        sel_mem    = 2'b00;
        sel_a      = 1'b0;
        sel_b      = 2'b00;
        ula_c      = 3'b000;
        sel_wreg   = 1'b0;
        sel_wdata  = 1'b0;
        sel_pc     = 2'b00;
        rst_out    = 1'b0;
        ovf_trap   = 1'b0;
        illegal_op = 1'b0;
        case (state_q)
            S_RESET: rst_out = 1'b1;
            S_FETCH1: begin
                ir_w  = 1'b1;
                pc_w  = 1'b1;
                sel_b = 2'b01;
                ula_c = 3'b001;
            end
            S_DECODE: begin
                ab_w  = 1'b1;
                alu_w = 1'b1;
                sel_b = 2'b11;
                ula_c = 3'b001;
            end
            S_EXEC_R: begin
                sel_a = 1'b1;
                ula_c = r_alu_op(fn_q);
                alu_w = 1'b1;
            end
            S_EXEC_I, S_MEM_ADDR: begin
                sel_a = 1'b1;
                sel_b = 2'b10;
                ula_c = 3'b001;
                alu_w = 1'b1;
            end
            S_WB_ALU: begin
                sel_wreg = (op_q == OP_RTYPE);
                rb_w     = ~ovf_q;
                ovf_trap = ovf_q;
            end
            S_MEM_RD0: sel_mem = 2'b01;
            S_MEM_RD1: begin
                sel_mem = 2'b01;
                mdr_w   = 1'b1;
            end
            S_WB_LW: begin
                sel_wdata = 1'b1;
                rb_w      = 1'b1;
            end
            S_MEM_WR: begin
                sel_mem = 2'b01;
                mem_w   = 1'b1;
            end
            S_BRANCH: begin
                sel_a  = 1'b1;
                ula_c  = 3'b010;
                sel_pc = 2'b01;
                pc_w   = zr;
            end
            S_JUMP: begin
                sel_pc = 2'b10;
                pc_w   = 1'b1;
            end
            S_ILLEGAL: illegal_op = 1'b1;
            default: ;
        endcase
    end

    assign state_o = state_q;

endmodule
